// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bf_pkg
//  Description : Shared opcodes and controller state encoding for bf_core.
//  Revision    : 1.0 - initial release
// ============================================================================
package bf_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_JZ    = 8'h5B;
    localparam logic [7:0] OP_JNZ   = 8'h5D;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_HALT  = 8'h00;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        SCAN_FWD  = 3'd2,
        SCAN_BACK = 3'd3,
        HALT      = 3'd4
    } bf_state_e;

endpackage
`default_nettype wire

// File: rtl/bf_core.sv
`default_nettype none
// ============================================================================
//  Module      : bf_core
//  Description : Brainfuck interpreter core. One instruction byte per step
//                from a synchronous code ROM, cells in a synchronous RAM,
//                character I/O over a valid/ready style RX/TX pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module bf_core
    import bf_pkg::*;
#(
    parameter int CODE_ADDR_W  = 5,
    parameter int ARRAY_ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              code_in,
    output logic [CODE_ADDR_W-1:0]  addr_code,
    input  logic [7:0]              data_in,
    output logic [ARRAY_ADDR_W-1:0] addr_array,
    output logic                    done,
    output logic [7:0]              data_out,
    output logic                    write_rq,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready
);

    localparam int DEPTH_W = CODE_ADDR_W + 1;

    bf_state_e                 r_state_q,      w_state_d;
    // Scan direction pending for the next fetch; FETCH means "not scanning",
    // which lets the scanner reuse the normal fetch cycle.
    bf_state_e                 r_scan_q,       w_scan_d;
    logic [CODE_ADDR_W-1:0]    r_addr_code_q,  w_addr_code_d;
    logic [ARRAY_ADDR_W-1:0]   r_addr_array_q, w_addr_array_d;
    logic [DEPTH_W-1:0]        r_depth_q,      w_depth_d;
    logic                      r_done_q,       w_done_d;
    logic                      r_write_rq_q,   w_write_rq_d;
    logic [7:0]                r_data_out_q,   w_data_out_d;
    logic                      r_tx_valid_q,   w_tx_valid_d;
    logic [7:0]                r_tx_data_q,    w_tx_data_d;

    logic                      w_fwd;
    logic [7:0]                w_open_op;
    logic [7:0]                w_close_op;
    logic [CODE_ADDR_W-1:0]    w_scan_step;

    // Bracket roles flip with scan direction so one datapath serves both.
    always_comb begin
        w_fwd       = (r_state_q == SCAN_FWD);
        w_open_op   = w_fwd ? OP_JZ  : OP_JNZ;
        w_close_op  = w_fwd ? OP_JNZ : OP_JZ;
        w_scan_step = w_fwd ? r_addr_code_q + CODE_ADDR_W'(1)
                            : r_addr_code_q - CODE_ADDR_W'(1);
    end

    // Next-state and registered-output computation for the controller.
    always_comb begin
        w_state_d      = r_state_q;
        w_scan_d       = r_scan_q;
        w_addr_code_d  = r_addr_code_q;
        w_addr_array_d = r_addr_array_q;
        w_depth_d      = r_depth_q;
        w_done_d       = r_done_q;
        w_write_rq_d   = 1'b0;
        w_data_out_d   = r_data_out_q;
        w_tx_valid_d   = 1'b0;
        w_tx_data_d    = r_tx_data_q;

        case (r_state_q)
            FETCH: begin
                w_state_d = (r_scan_q == FETCH) ? DECODE : r_scan_q;
            end

            DECODE: begin
                w_state_d     = FETCH;
                w_addr_code_d = r_addr_code_q + CODE_ADDR_W'(1);
                case (code_in)
                    OP_INC: begin
                        w_write_rq_d = 1'b1;
                        w_data_out_d = data_in + 8'd1;
                    end
                    OP_DEC: begin
                        w_write_rq_d = 1'b1;
                        w_data_out_d = data_in - 8'd1;
                    end
                    OP_RIGHT: w_addr_array_d = r_addr_array_q + ARRAY_ADDR_W'(1);
                    OP_LEFT:  w_addr_array_d = r_addr_array_q - ARRAY_ADDR_W'(1);
                    OP_OUT: begin
                        if (tx_ready) begin
                            w_tx_valid_d = 1'b1;
                            w_tx_data_d  = data_in;
                        end else begin
                            w_state_d     = DECODE;
                            w_addr_code_d = r_addr_code_q;
                        end
                    end
                    OP_IN: begin
                        if (rx_valid) begin
                            w_write_rq_d = 1'b1;
                            w_data_out_d = rx_data;
                        end else begin
                            w_state_d     = DECODE;
                            w_addr_code_d = r_addr_code_q;
                        end
                    end
                    OP_JZ: begin
                        if (data_in == 8'd0) begin
                            w_depth_d = DEPTH_W'(1);
                            w_scan_d  = SCAN_FWD;
                        end
                    end
                    OP_JNZ: begin
                        if (data_in != 8'd0) begin
                            w_depth_d     = DEPTH_W'(1);
                            w_scan_d      = SCAN_BACK;
                            w_addr_code_d = r_addr_code_q - CODE_ADDR_W'(1);
                        end
                    end
                    OP_HALT: begin
                        w_state_d     = HALT;
                        w_done_d      = 1'b1;
                        w_addr_code_d = r_addr_code_q;
                    end
                    default: ;
                endcase
            end

            SCAN_FWD, SCAN_BACK: begin
                w_state_d     = FETCH;
                w_addr_code_d = w_scan_step;
                if (code_in == OP_HALT) begin
                    w_state_d     = HALT;
                    w_done_d      = 1'b1;
                    w_scan_d      = FETCH;
                    w_addr_code_d = r_addr_code_q;
                end else if (code_in == w_close_op) begin
                    w_depth_d = r_depth_q - DEPTH_W'(1);
                    if (r_depth_q == DEPTH_W'(1)) begin
                        // Matching bracket found: resume just past it.
                        w_scan_d      = FETCH;
                        w_addr_code_d = r_addr_code_q + CODE_ADDR_W'(1);
                    end
                end else if (code_in == w_open_op) begin
                    w_depth_d = r_depth_q + DEPTH_W'(1);
                end
            end

            HALT: begin
                w_state_d = HALT;
                w_done_d  = 1'b1;
            end

            default: w_state_d = FETCH;
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= FETCH;
            r_scan_q       <= FETCH;
            r_addr_code_q  <= '0;
            r_addr_array_q <= '0;
            r_depth_q      <= '0;
            r_done_q       <= 1'b0;
            r_write_rq_q   <= 1'b0;
            r_data_out_q   <= 8'd0;
            r_tx_valid_q   <= 1'b0;
            r_tx_data_q    <= 8'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_scan_q       <= w_scan_d;
            r_addr_code_q  <= w_addr_code_d;
            r_addr_array_q <= w_addr_array_d;
            r_depth_q      <= w_depth_d;
            r_done_q       <= w_done_d;
            r_write_rq_q   <= w_write_rq_d;
            r_data_out_q   <= w_data_out_d;
            r_tx_valid_q   <= w_tx_valid_d;
            r_tx_data_q    <= w_tx_data_d;
        end
    end

    assign addr_code  = r_addr_code_q;
    assign addr_array = r_addr_array_q;
    assign done       = r_done_q;
    assign write_rq   = r_write_rq_q;
    assign data_out   = r_data_out_q;
    assign tx_valid   = r_tx_valid_q;
    assign tx_data    = r_tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_bf_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bf_core
//  Description : Self-checking bench for bf_core against a behavioural
//                Brainfuck interpreter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bf_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] code_in;
    logic [4:0] addr_code;
    logic [7:0] data_in;
    logic [4:0] addr_array;
    logic       done;
    logic [7:0] data_out;
    logic       write_rq;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    always #5 clk = ~clk;

    bf_core #(.CODE_ADDR_W(5), .ARRAY_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .code_in(code_in), .addr_code(addr_code),
        .data_in(data_in), .addr_array(addr_array), .done(done),
        .data_out(data_out), .write_rq(write_rq), .rx_valid(rx_valid),
        .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready)
    );

    // Memories: 16-entry ROM, write-first 32x8 RAM cleared on reset.
    logic [7:0] rom [16];
    logic [7:0] ram [32];

    always @(posedge clk) begin
        code_in <= rom[addr_code[3:0]];
        if (reset) begin
            for (int i = 0; i < 32; i++) ram[i] <= 8'd0;
            data_in <= 8'd0;
        end else if (write_rq) begin
            ram[addr_array] <= data_out;
            data_in         <= data_out;
        end else begin
            data_in <= ram[addr_array];
        end
    end

    // tx_ready driver: 0 = held low, 1 = held high, 2 = random per cycle.
    int tx_mode = 1;
    always @(negedge clk) begin
        case (tx_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor, sampled mid-cycle.
    logic [7:0] mon_tx[$];
    int         mon_wr;
    int         mon_overlap;
    always @(negedge clk) begin
        if (reset) begin
            mon_tx.delete();
            mon_wr      = 0;
            mon_overlap = 0;
        end else begin
            if (tx_valid) mon_tx.push_back(tx_data);
            if (write_rq) mon_wr++;
            if (tx_valid && write_rq) mon_overlap++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural interpreter model ----------------
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    logic [7:0] m_cells [32];
    logic [4:0] m_dp;
    int         m_ip;
    int         m_writes;

    function automatic logic [7:0] at(input string p, input int j);
        int k = j % 16;
        return (k < p.len()) ? p[k] : 8'h00;
    endfunction

    function automatic void model(input string p);
        bit         halted = 0;
        int         d;
        int         j;
        logic [7:0] c;
        m_tx.delete();
        for (int i = 0; i < 32; i++) m_cells[i] = 8'd0;
        m_dp = 5'd0; m_ip = 0; m_writes = 0;
        for (int s = 0; s < 20000 && !halted; s++) begin
            c = at(p, m_ip);
            case (c)
                "+": begin m_cells[m_dp] = m_cells[m_dp] + 8'd1; m_writes++; m_ip++; end
                "-": begin m_cells[m_dp] = m_cells[m_dp] - 8'd1; m_writes++; m_ip++; end
                ">": begin m_dp = m_dp + 5'd1; m_ip++; end
                "<": begin m_dp = m_dp - 5'd1; m_ip++; end
                ".": begin m_tx.push_back(m_cells[m_dp]); m_ip++; end
                ",": begin m_cells[m_dp] = m_rx.pop_front(); m_writes++; m_ip++; end
                "[", "]": begin
                    if ((c == "[") == (m_cells[m_dp] == 8'd0)) begin
                        d = 1; j = m_ip;
                        while (d > 0 && !halted) begin
                            j = (c == "[") ? (j + 1) % 32 : (j + 31) % 32;
                            if (at(p, j) == 8'h00)      halted = 1;
                            else if (at(p, j) == c)     d++;
                            else if (at(p, j) != 8'h00 && (at(p, j) == "[" || at(p, j) == "]")) d--;
                        end
                        m_ip = halted ? j : j + 1;
                    end else begin
                        m_ip++;
                    end
                end
                8'h00: halted = 1;
                default: m_ip++;
            endcase
            m_ip = m_ip % 32;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_prog(input string p);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = (i < p.len()) ? p[i] : 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_addr_code",  32'(addr_code),  32'd0);
        chk("rst_addr_array", 32'(addr_array), 32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_strobes",    32'({write_rq, tx_valid}), 32'd0);
        chk("rst_data",       32'({data_out, tx_data}),  32'd0);
        reset = 1'b0;
    endtask

    task automatic finish_prog(input string tag);
        int n;
        for (int c = 0; c < 4000 && !done; c++) @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_txcount"}, 32'(mon_tx.size()), 32'(m_tx.size()));
        n = (mon_tx.size() < m_tx.size()) ? mon_tx.size() : m_tx.size();
        for (int i = 0; i < n; i++) chk({tag, "_txdata"}, 32'(mon_tx[i]), 32'(m_tx[i]));
        chk({tag, "_writes"}, 32'(mon_wr), 32'(m_writes));
        for (int i = 0; i < 32; i++) chk({tag, "_cell"}, 32'(ram[i]), 32'(m_cells[i]));
        chk({tag, "_dp"}, 32'(addr_array), 32'(m_dp));
        chk({tag, "_haltpc"}, 32'(addr_code), 32'(m_ip));
        chk({tag, "_overlap"}, 32'(mon_overlap), 32'd0);
        repeat (6) @(negedge clk);
        chk({tag, "_sticky"}, 32'({done, 8'(mon_tx.size()), 8'(mon_wr)}),
            32'({1'b1, 8'(m_tx.size()), 8'(m_writes)}));
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        string      p;
        string      alph = "+-<>.x";
        logic [7:0] rxc;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;

        // Basic increment and output, random tx backpressure.
        tx_mode = 2;
        p = "+++.";
        model(p); start_prog(p); finish_prog("inc3");

        // Loop moving a value to the next cell.
        p = "++[->+<]>.";
        model(p); start_prog(p); finish_prog("loop");

        // Input stall for 1000 cycles, then a single received character.
        tx_mode = 1;
        rxc = 8'h20;
        p = ",.";
        m_rx.delete(); m_rx.push_back(rxc);
        model(p); start_prog(p);
        repeat (1000) @(negedge clk);
        chk("rx_stall_writes", 32'(mon_wr), 32'd0);
        chk("rx_stall_tx",     32'(mon_tx.size()), 32'd0);
        rx_valid = 1'b1; rx_data = rxc;
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'h00;
        finish_prog("rx");

        // Same with a random character.
        rxc = 8'($urandom_range(1, 255));
        m_rx.delete(); m_rx.push_back(rxc);
        model(p); start_prog(p);
        repeat (20) @(negedge clk);
        rx_valid = 1'b1; rx_data = rxc;
        @(negedge clk);
        rx_valid = 1'b0;
        finish_prog("rxr");

        // Underflow, pointer wrap, transmit held off by tx_ready.
        tx_mode = 0;
        p = "-<.";
        model(p); start_prog(p);
        repeat (50) @(negedge clk);
        chk("wrap_cell0", 32'(ram[0]), 32'hFF);
        chk("wrap_dp",    32'(addr_array), 32'd31);
        chk("wrap_notx",  32'(mon_tx.size()), 32'd0);
        tx_mode = 1;
        finish_prog("wrap");

        // Loop body skipped when the cell is zero.
        tx_mode = 2;
        p = "[+++.]+.";
        model(p); start_prog(p); finish_prog("skip");

        // Unmatched bracket scan runs into NUL.
        p = "[++";
        model(p); start_prog(p); finish_prog("scanhalt");

        // Random loop-free programs.
        for (int r = 0; r < 3; r++) begin
            p = "";
            for (int k = 0; k < int'($urandom_range(6, 14)); k++)
                p = $sformatf("%s%c", p, alph[$urandom_range(0, 5)]);
            model(p); start_prog(p); finish_prog("rand");
        end

        // Reset in the middle of the loop, then full rerun.
        p = "++[->+<]>.";
        model(p); start_prog(p);
        repeat (22) @(negedge clk);
        chk("mid_notdone", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_addr_code",  32'(addr_code),  32'd0);
        chk("mid_addr_array", 32'(addr_array), 32'd0);
        chk("mid_done",       32'(done),       32'd0);
        chk("mid_strobes",    32'({write_rq, tx_valid}), 32'd0);
        reset = 1'b0;
        finish_prog("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bf_core.md
Name: bf_core

Overview:
- Brainfuck interpreter core.
- Fetches one instruction byte per step from an external synchronous-read code ROM.
- Operates on an external synchronous-read/synchronous-write data-array RAM through a data pointer.
- Exchanges characters with a UART-style RX/TX interface; asserts done on reaching a NUL instruction.

Parameters:
CODE_ADDR_W, 5, width of code address (code space 2^CODE_ADDR_W bytes)
ARRAY_ADDR_W, 5, width of data-array address (2^ARRAY_ADDR_W cells of 8 bits)

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
code_in  in  8  instruction byte from ROM; valid one cycle after addr_code is presented
addr_code  out  CODE_ADDR_W  instruction pointer to ROM
data_in  in  8  cell value from RAM; valid one cycle after addr_array is presented
addr_array  out  ARRAY_ADDR_W  data pointer, used as both RAM read and write address
done  out  1  program halted (sticky)
data_out  out  8  cell write data
write_rq  out  1  one-cycle RAM write strobe
rx_valid  in  1  received character available
rx_data  in  8  received character
tx_valid  out  1  one-cycle transmit strobe
tx_data  out  8  character to transmit
tx_ready  in  1  transmitter can accept a character

Behaviour:
- Reset (sync, high): state=FETCH, addr_code=0, addr_array=0, depth=0; done, write_rq and tx_valid=0; data_out and tx_data=0.
  - The core does not clear the RAM; the system provides a zero-initialised array.
  - Reset mid-instruction or mid-scan aborts immediately; no write_rq or tx_valid is issued in the reset cycle.
- Memories have 1-cycle read latency. RAM write at a clock edge is visible on data_in at the next FETCH->DECODE edge.
- FETCH (1 cycle): drive addr_code and addr_array; go to DECODE.
- DECODE: code_in and data_in are valid. Normal instructions take 2 cycles in total.
  - 0x2B '+': write_rq=1, data_out=data_in+1 mod 256; addr_code+1.
  - 0x2D '-': write_rq=1, data_out=data_in-1 mod 256 (0 becomes 0xFF); addr_code+1.
  - 0x3E '>' / 0x3C '<': addr_array +/-1, wrapping mod 2^ARRAY_ADDR_W; addr_code+1.
  - 0x2E '.': stall in DECODE while tx_ready=0. When tx_ready=1: tx_valid=1 for exactly one cycle, tx_data=data_in; addr_code+1.
  - 0x2C ',': stall in DECODE while rx_valid=0. When rx_valid=1: write_rq=1, data_out=rx_data; addr_code+1. Consumes one character per ','.
  - 0x5B '[': if data_in!=0, addr_code+1. Else depth=1, addr_code+1, enter SCAN_FWD.
  - 0x5D ']': if data_in==0, addr_code+1. Else depth=1, addr_code-1, enter SCAN_BACK.
  - 0x00: enter HALT.
  - Any other byte: no-op, addr_code+1.
- SCAN_FWD / SCAN_BACK: 2 cycles per scanned byte (fetch, inspect).
  - Forward scan: '[' gives depth+1; ']' gives depth-1.
  - Backward scan: ']' gives depth+1; '[' gives depth-1.
  - When depth reaches 0, addr_code = matching bracket + 1, then FETCH.
  - Otherwise step addr_code by +1 (forward) or -1 (backward), wrapping.
  - NUL encountered during any scan: HALT.
  - depth counter is CODE_ADDR_W+1 bits.
- HALT: done=1, sticky until reset; no further writes or transmits; addr_code held.
- addr_code wraps mod 2^CODE_ADDR_W.
- write_rq and tx_valid are never asserted together or for more than one cycle per instruction.

Decomposition:
- Shared package bf_pkg:
  - opcode constants OP_INC 8'h2B, OP_DEC 8'h2D, OP_RIGHT 8'h3E, OP_LEFT 8'h3C, OP_JZ 8'h5B, OP_JNZ 8'h5D, OP_OUT 8'h2E, OP_IN 8'h2C, OP_HALT 8'h00.
  - state enum {FETCH, DECODE, SCAN_FWD, SCAN_BACK, HALT}.
- Single module; no sub-module. The bracket scanner is one state pair sharing the fetch path.
- Bench models: 1-cycle-latency ROM (16 entries, addr_code[3:0]) and 2^5 x 8 RAM, zero on reset.

Test Plan:
- ROM "+++.",0: tx_valid pulses once with tx_data=0x03; done=1 afterwards; exactly 3 write_rq pulses.
- ROM "++[->+<]>.",0: one transmit of 0x02; cell0=0x00, cell1=0x02 at done.
- ROM ",.",0 with rx_valid held 0 for 1000 cycles then pulsed with rx_data=0x20: core stalls with no write_rq; then writes 0x20 and transmits 0x20.
- ROM "-<.",0 with tx_ready=0 for 50 cycles: cell0=0xFF, addr_array=31, no tx_valid while tx_ready=0; then a single tx of 0x00.
- ROM "[+++.]+.",0 (cell zero): loop body skipped; single tx 0x01.
- Assert reset mid-loop of the second program: next cycle addr_code=0, addr_array=0, done=0, no strobes; program reruns from the start.
